fpu_request_arbiter: RTL and testbench
======================================

# fpu_request_arbiter

Shares one `floating_point_unit` instance among `NUM_REQ` independent requesters. It arbitrates round-robin, latches the winner's operands, sequences the FPU's start/done/reset handshake, and routes the result and flags back to the granted requester. A watchdog aborts operations that never complete. It sits directly in front of the FPU and replaces per-client FPU instances.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 255: maximum cycles from ISSUE entry to `fpu_done` before abort.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_ready` out NUM_REQ: one-hot grant; operands accepted this cycle.
- `req_op` in 2*NUM_REQ: opcode for requester i at [2i+1:2i].
- `req_a`, `req_b` in 32*NUM_REQ: IEEE-754 single operands, slice [32i+31:32i].
- `rsp_valid` out NUM_REQ: one-hot, one-cycle response strobe.
- `rsp_z` out 32: result, valid with `rsp_valid`.
- `rsp_overflow`, `rsp_underflow`, `rsp_timeout` out 1: flags, valid with `rsp_valid`.
- `fpu_start` out 1, `fpu_op` out 2, `fpu_a`, `fpu_b` out 32: FPU command.
- `fpu_rst` out 1: FPU reset, active-high.
- `fpu_z` in 32, `fpu_overflow`, `fpu_underflow`, `fpu_busy`, `fpu_done` in 1: FPU status.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, CLEAR. Reset state is IDLE.
- IDLE: if any `req_valid` is set, pick the winner g, the first set bit searching upward from `last_grant+1` with wrap. Drive `req_ready[g]=1` combinationally, latch `req_op/a/b[g]` into `fpu_op/a/b`, store g, then go to ISSUE. `req_ready` is 0 in every other state.
- ISSUE: `fpu_start=1`. Clear the timeout counter on entry, then increment it each cycle in ISSUE and WAIT.
  - `fpu_done=1`: capture the result, go to RESP.
  - Otherwise `fpu_busy=1`: go to WAIT.
- WAIT: `fpu_start=0`. Route by priority:
  - `fpu_done=1`: capture `fpu_z` and both flags, go to RESP.
  - Counter reaches `TIMEOUT_CYCLES`: capture z=0, flags 0, `rsp_timeout=1`, go to RESP.
  - `fpu_done` has priority over timeout in the same cycle.
- RESP: `rsp_valid[g]=1` for exactly one cycle. There is no backpressure; requesters must sample. `last_grant<=g`. Go to CLEAR.
- CLEAR: `fpu_rst=1` for one cycle, clearing FPU done/flags. Go to IDLE.
- Operands stay stable on `fpu_op/a/b` from ISSUE through WAIT. Requester input changes after grant are ignored.
- Opcodes come from the package: ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11. The block does no arithmetic, only routing.

## Timing
- Reset values while `rst` is low:
  - state IDLE.
  - `req_ready`, `rsp_valid`, `fpu_start` = 0.
  - `fpu_op/a/b`, `rsp_z`, all `rsp_*` flags = 0.
  - `fpu_rst` = 1, which holds the FPU in reset.
  - `last_grant` = NUM_REQ-1, so requester 0 wins first.
- All outputs are registered except `req_ready`, which is combinational in IDLE.
- Cycle sequence:
  - Cycle 0: grant.
  - Cycle 1: ISSUE.
  - `rsp_valid` rises 1 cycle after `fpu_done` is sampled.
  - CLEAR follows, and the next grant can happen the cycle after CLEAR.
  - Minimum request-to-response, with `fpu_done` in ISSUE, is 2 cycles. Arbitration overhead is 3 cycles per operation.
- Reset mid-operation: immediate abort. No `rsp_valid` is issued for the aborted request, and `fpu_rst` stays high until `rst` deasserts.
- A still-valid requester is regranted only in its round-robin turn. Starvation bound: NUM_REQ-1 operations.

## Structure
- Package `fpu_pkg`: opcode constants, FSM state enum, `FP_W=32`. Shared with `floating_point_unit` and benches.
- Sub-module `fpu_rr_picker`: combinational round-robin, (`req_valid`, `last_grant`) → one-hot grant + index.
- Top contains the FSM, operand/result registers, and the timeout counter.

## Test plan
- Single request: req0 MUL a=0x3F800000, b=0x40000000.
  - → `fpu_op=2'b10`, `fpu_start` high until busy.
  - → `rsp_valid[0]` one cycle, `rsp_z=0x40000000`, flags 0.
  - → one `fpu_rst` pulse follows.
- All four valid continuously with distinct ADDs.
  - → grants in order 0,1,2,3,0; each `rsp_valid[i]` matches its grant.
  - → no two `req_ready` bits set in the same cycle.
- Stub FPU never asserts `fpu_done`.
  - → `rsp_valid` and `rsp_timeout=1` with z=0 exactly `TIMEOUT_CYCLES` after ISSUE entry.
  - → the next requester is then served normally.
- `fpu_done` and counter==`TIMEOUT_CYCLES` in the same cycle → `rsp_timeout=0`, captured z returned.
- Reset asserted during WAIT (req2 DIV 0x7F7FFFFF/0x00800000).
  - → all outputs reach reset values asynchronously; no `rsp_valid`.
  - → after release, requester 0 is granted first.
- Overflow case: MUL 0x7F7FFFFF × 0x40000000 → `rsp_overflow=1`, copied from the FPU in the `rsp_valid` cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand width, opcodes and the arbiter state encoding.
package fpu_pkg;

    localparam int FP_W = 32;
    localparam int OP_W = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_CLEAR = 3'd4
    } arb_state_e;

endpackage

// File: rtl/fpu_rr_picker.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
module fpu_rr_picker
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] idx_s;
    logic             hit_s;

    // Walk the ring starting one past last_grant; the first hit wins and masks later ones.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        grant_idx = '0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s        = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            hit_s        = req_valid[idx_s] & ~any_valid;
            any_valid    = any_valid | hit_s;
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx    = hit_s ? idx_s : grant_idx;
        end
    end

endmodule

// File: rtl/fpu_request_arbiter.sv
// Shares one FPU among NUM_REQ requesters: round-robin grant, operand latch,
// start/done/reset sequencing, watchdog abort and one-hot response routing.
module fpu_request_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OP_W*NUM_REQ-1:0]   req_op,
    input  logic [FP_W*NUM_REQ-1:0]   req_a,
    input  logic [FP_W*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [FP_W-1:0]           rsp_z,
    output logic                      rsp_overflow,
    output logic                      rsp_underflow,
    output logic                      rsp_timeout,
    output logic                      fpu_start,
    output logic [OP_W-1:0]           fpu_op,
    output logic [FP_W-1:0]           fpu_a,
    output logic [FP_W-1:0]           fpu_b,
    output logic                      fpu_rst,
    input  logic [FP_W-1:0]           fpu_z,
    input  logic                      fpu_overflow,
    input  logic                      fpu_underflow,
    input  logic                      fpu_busy,
    input  logic                      fpu_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // cnt_r holds cycles already spent, so this value marks the TIMEOUT_CYCLES-th cycle.
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] GRANT_LSB = NUM_REQ'(1);

    arb_state_e         state_r;
    logic [IDX_W-1:0]   last_grant_r;
    logic [IDX_W-1:0]   grant_idx_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [OP_W-1:0]    fpu_op_r;
    logic [FP_W-1:0]    fpu_a_r;
    logic [FP_W-1:0]    fpu_b_r;
    logic               fpu_start_r;
    logic               fpu_rst_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [FP_W-1:0]    rsp_z_r;
    logic               rsp_overflow_r;
    logic               rsp_underflow_r;
    logic               rsp_timeout_r;

    logic               any_valid_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               timeout_s;

    fpu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_valid  (req_valid),
        .last_grant (last_grant_r),
        .any_valid  (any_valid_s),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    assign timeout_s = (cnt_r == CNT_LAST);

    // Grant is offered straight from the picker, only while idle and out of reset.
    always_comb begin
        if (rst && (state_r == ST_IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Arbiter FSM with operand/result registers and the watchdog counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            last_grant_r    <= IDX_W'(NUM_REQ - 1);
            grant_idx_r     <= '0;
            cnt_r           <= '0;
            fpu_op_r        <= '0;
            fpu_a_r         <= '0;
            fpu_b_r         <= '0;
            fpu_start_r     <= 1'b0;
            fpu_rst_r       <= 1'b1;
            rsp_valid_r     <= '0;
            rsp_z_r         <= '0;
            rsp_overflow_r  <= 1'b0;
            rsp_underflow_r <= 1'b0;
            rsp_timeout_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    fpu_rst_r <= 1'b0;
                    if (any_valid_s) begin
                        fpu_op_r    <= req_op[grant_idx_s*OP_W +: OP_W];
                        fpu_a_r     <= req_a[grant_idx_s*FP_W +: FP_W];
                        fpu_b_r     <= req_b[grant_idx_s*FP_W +: FP_W];
                        grant_idx_r <= grant_idx_s;
                        cnt_r       <= '0;
                        fpu_start_r <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (fpu_done) begin
                        rsp_z_r         <= fpu_z;
                        rsp_overflow_r  <= fpu_overflow;
                        rsp_underflow_r <= fpu_underflow;
                        rsp_timeout_r   <= 1'b0;
                        rsp_valid_r     <= GRANT_LSB << grant_idx_r;
                        fpu_start_r     <= 1'b0;
                        state_r         <= ST_RESP;
                    end else if (timeout_s) begin
                        rsp_z_r         <= '0;
                        rsp_overflow_r  <= 1'b0;
                        rsp_underflow_r <= 1'b0;
                        rsp_timeout_r   <= 1'b1;
                        rsp_valid_r     <= GRANT_LSB << grant_idx_r;
                        fpu_start_r     <= 1'b0;
                        state_r         <= ST_RESP;
                    end else if ((state_r == ST_ISSUE) && fpu_busy) begin
                        fpu_start_r <= 1'b0;
                        state_r     <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    rsp_valid_r  <= '0;
                    last_grant_r <= grant_idx_r;
                    fpu_rst_r    <= 1'b1;
                    state_r      <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    fpu_rst_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    fpu_start_r <= 1'b0;
                    rsp_valid_r <= '0;
                    fpu_rst_r   <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign fpu_start     = fpu_start_r;
    assign fpu_op        = fpu_op_r;
    assign fpu_a         = fpu_a_r;
    assign fpu_b         = fpu_b_r;
    assign fpu_rst       = fpu_rst_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_z         = rsp_z_r;
    assign rsp_overflow  = rsp_overflow_r;
    assign rsp_underflow = rsp_underflow_r;
    assign rsp_timeout   = rsp_timeout_r;

endmodule

// File: tb/tb_fpu_request_arbiter.sv
// Directed bench for fpu_request_arbiter; the bench itself plays the FPU stub.
module tb_fpu_request_arbiter;
    import fpu_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 255;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_z;
    logic              rsp_overflow;
    logic              rsp_underflow;
    logic              rsp_timeout;
    logic              fpu_start;
    logic [1:0]        fpu_op;
    logic [31:0]       fpu_a;
    logic [31:0]       fpu_b;
    logic              fpu_rst;
    logic [31:0]       fpu_z;
    logic              fpu_overflow;
    logic              fpu_underflow;
    logic              fpu_busy;
    logic              fpu_done;

    int total = 0;
    int bad   = 0;

    fpu_request_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_overflow(rsp_overflow),
        .rsp_underflow(rsp_underflow), .rsp_timeout(rsp_timeout),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_rst(fpu_rst), .fpu_z(fpu_z), .fpu_overflow(fpu_overflow),
        .fpu_underflow(fpu_underflow), .fpu_busy(fpu_busy), .fpu_done(fpu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b0000; req_op = '0; req_a = '0; req_b = '0;
        fpu_z = 32'h0; fpu_overflow = 1'b0; fpu_underflow = 1'b0;
        fpu_busy = 1'b0; fpu_done = 1'b0;
        #2 rst = 1'b0;
        req_valid = 4'b1111;
        #2;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0000); end
        total++; if (fpu_rst !== 1'b1) begin bad++; $display("FAIL reset_fpu_rst got=%b exp=1", fpu_rst); end
        total++; if ({fpu_start, rsp_valid, rsp_timeout, rsp_overflow, rsp_underflow} !== 8'h00) begin
            bad++; $display("FAIL reset_ctl got=%b exp=%b", {fpu_start, rsp_valid, rsp_timeout, rsp_overflow, rsp_underflow}, 8'h00); end
        total++; if ({fpu_op, fpu_a, fpu_b, rsp_z} !== 98'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {fpu_op, fpu_a, fpu_b, rsp_z}); end
        req_valid = 4'b0000;
        tick(); tick();
        rst = 1'b1;
        tick();
        total++; if (fpu_rst !== 1'b0) begin bad++; $display("FAIL reset_release_fpu_rst got=%b exp=0", fpu_rst); end
    endtask

    task automatic test_round_robin();
        int exp;
        logic [3:0] exp_oh;
        req_op = 8'h00;
        req_a  = {32'h3F80_0003, 32'h3F80_0002, 32'h3F80_0001, 32'h3F80_0000};
        req_b  = {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = k % 4;
            exp_oh = 4'b0001 << exp;
            #1;
            total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, req_ready, exp_oh); end
            tick();
            total++; if (fpu_a !== 32'h3F80_0000 + 32'(exp) || fpu_start !== 1'b1 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL rr_issue[%0d] a=%h start=%b ready=%b exp a=%h start=1 ready=0000", k, fpu_a, fpu_start, req_ready, 32'h3F80_0000 + 32'(exp)); end
            fpu_done = 1'b1; fpu_z = 32'h4100_0000 + 32'(k);
            tick();
            total++; if (rsp_valid !== exp_oh || rsp_z !== 32'h4100_0000 + 32'(k)) begin
                bad++; $display("FAIL rr_resp[%0d] valid=%b z=%h exp valid=%b z=%h", k, rsp_valid, rsp_z, exp_oh, 32'h4100_0000 + 32'(k)); end
            fpu_done = 1'b0;
            tick();
            tick();
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_single();
        req_op = {6'b0, OP_MUL};
        req_a  = {96'h0, 32'h3F80_0000};
        req_b  = {96'h0, 32'h4000_0000};
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        tick();
        total++; if (fpu_op !== 2'b10 || fpu_a !== 32'h3F80_0000 || fpu_b !== 32'h4000_0000 || fpu_start !== 1'b1) begin
            bad++; $display("FAIL single_issue op=%b a=%h b=%h start=%b exp 10 3f800000 40000000 1", fpu_op, fpu_a, fpu_b, fpu_start); end
        req_valid = 4'b0000; req_a = {96'h0, 32'hFFFF_FFFF}; fpu_busy = 1'b1;
        tick();
        total++; if (fpu_start !== 1'b0 || fpu_a !== 32'h3F80_0000) begin
            bad++; $display("FAIL single_wait start=%b a=%h exp 0 3f800000", fpu_start, fpu_a); end
        tick();
        fpu_done = 1'b1; fpu_busy = 1'b0; fpu_z = 32'h4000_0000;
        tick();
        total++; if (rsp_valid !== 4'b0001 || rsp_z !== 32'h4000_0000) begin
            bad++; $display("FAIL single_resp valid=%b z=%h exp 0001 40000000", rsp_valid, rsp_z); end
        total++; if ({rsp_overflow, rsp_underflow, rsp_timeout} !== 3'b000 || fpu_rst !== 1'b0) begin
            bad++; $display("FAIL single_flags flags=%b fpu_rst=%b exp 000 0", {rsp_overflow, rsp_underflow, rsp_timeout}, fpu_rst); end
        fpu_done = 1'b0;
        tick();
        total++; if (rsp_valid !== 4'b0000 || fpu_rst !== 1'b1) begin
            bad++; $display("FAIL single_clear valid=%b fpu_rst=%b exp 0000 1", rsp_valid, fpu_rst); end
        tick();
        total++; if (fpu_rst !== 1'b0) begin bad++; $display("FAIL single_rst_pulse got=%b exp=0", fpu_rst); end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        req_op = 8'h00;
        req_valid = 4'b0110;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL tmo_grant got=%b exp=0010", req_ready); end
        tick();
        req_valid = 4'b0100; fpu_busy = 1'b1; fpu_z = 32'hDEAD_BEEF; fpu_overflow = 1'b1;
        for (int i = 1; i < TMO; i++) begin
            tick();
            if (rsp_valid !== 4'b0000) early++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL tmo_early got=%0d exp=0", early); end
        tick();
        total++; if (rsp_valid !== 4'b0010 || rsp_timeout !== 1'b1 || rsp_z !== 32'h0 || rsp_overflow !== 1'b0) begin
            bad++; $display("FAIL tmo_resp valid=%b to=%b z=%h ov=%b exp 0010 1 0 0", rsp_valid, rsp_timeout, rsp_z, rsp_overflow); end
        fpu_busy = 1'b0; fpu_overflow = 1'b0; fpu_z = 32'h0;
        tick();
        tick();
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL tmo_next_grant got=%b exp=0100", req_ready); end
        tick();
        req_valid = 4'b0000; fpu_done = 1'b1; fpu_z = 32'h4040_0000;
        tick();
        total++; if (rsp_valid !== 4'b0100 || rsp_timeout !== 1'b0 || rsp_z !== 32'h4040_0000) begin
            bad++; $display("FAIL tmo_next_resp valid=%b to=%b z=%h exp 0100 0 40400000", rsp_valid, rsp_timeout, rsp_z); end
        fpu_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_done_at_timeout();
        req_valid = 4'b1000;
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL tie_grant got=%b exp=1000", req_ready); end
        tick();
        req_valid = 4'b0000; fpu_busy = 1'b1;
        for (int i = 1; i < TMO; i++) begin
            tick();
            if (i == TMO - 1) begin
                fpu_done = 1'b1; fpu_z = 32'h1234_5678;
            end
        end
        tick();
        total++; if (rsp_valid !== 4'b1000 || rsp_timeout !== 1'b0 || rsp_z !== 32'h1234_5678) begin
            bad++; $display("FAIL tie_resp valid=%b to=%b z=%h exp 1000 0 12345678", rsp_valid, rsp_timeout, rsp_z); end
        fpu_done = 1'b0; fpu_busy = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_overflow();
        req_op = {6'b0, OP_MUL};
        req_a  = {96'h0, 32'h7F7F_FFFF};
        req_b  = {96'h0, 32'h4000_0000};
        req_valid = 4'b0001;
        tick();
        total++; if (fpu_op !== 2'b10 || fpu_a !== 32'h7F7F_FFFF) begin
            bad++; $display("FAIL ovf_issue op=%b a=%h exp 10 7f7fffff", fpu_op, fpu_a); end
        req_valid = 4'b0000; fpu_busy = 1'b1;
        tick();
        fpu_done = 1'b1; fpu_busy = 1'b0; fpu_z = 32'h7F80_0000; fpu_overflow = 1'b1;
        tick();
        total++; if (rsp_valid !== 4'b0001 || rsp_overflow !== 1'b1 || rsp_underflow !== 1'b0 || rsp_z !== 32'h7F80_0000) begin
            bad++; $display("FAIL ovf_resp valid=%b ov=%b un=%b z=%h exp 0001 1 0 7f800000", rsp_valid, rsp_overflow, rsp_underflow, rsp_z); end
        fpu_done = 1'b0; fpu_overflow = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        req_op = {2'b00, OP_DIV, 2'b00, 2'b00};
        req_a  = {32'h0, 32'h7F7F_FFFF, 32'h0, 32'h3F00_0000};
        req_b  = {32'h0, 32'h0080_0000, 32'h0, 32'h3F00_0000};
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rstmid_grant got=%b exp=0100", req_ready); end
        tick();
        total++; if (fpu_op !== 2'b11 || fpu_a !== 32'h7F7F_FFFF || fpu_b !== 32'h0080_0000) begin
            bad++; $display("FAIL rstmid_issue op=%b a=%h b=%h exp 11 7f7fffff 00800000", fpu_op, fpu_a, fpu_b); end
        req_valid = 4'b0000; fpu_busy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        req_valid = 4'b0101;
        #1;
        total++; if (fpu_rst !== 1'b1 || fpu_start !== 1'b0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL rstmid_async rst=%b start=%b ready=%b exp 1 0 0000", fpu_rst, fpu_start, req_ready); end
        total++; if ({fpu_op, fpu_a, fpu_b} !== 66'h0) begin bad++; $display("FAIL rstmid_operands got=%h exp=0", {fpu_op, fpu_a, fpu_b}); end
        fpu_done = 1'b1;
        tick();
        total++; if (rsp_valid !== 4'b0000 || fpu_rst !== 1'b1) begin
            bad++; $display("FAIL rstmid_hold valid=%b fpu_rst=%b exp 0000 1", rsp_valid, fpu_rst); end
        fpu_done = 1'b0; fpu_busy = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_first_grant got=%b exp=0001", req_ready); end
        tick();
        total++; if (fpu_a !== 32'h3F00_0000 || rsp_valid !== 4'b0000) begin
            bad++; $display("FAIL rstmid_after a=%h valid=%b exp 3f000000 0000", fpu_a, rsp_valid); end
        req_valid = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_done_at_timeout();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
